// File: rtl/day10_lane_dispatcher.sv
// Round-robin job dispatcher over NUM_LANES solver lanes with in-order result collection.
// Optional statistics counters are enabled by defining DAY10_DISPATCH_STATS_EN.
module day10_lane_dispatcher #(
    parameter int NUM_LANES = 4,
    parameter int JOB_W     = 64,
    parameter int RES_W     = 16,
    parameter int CNT_W     = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [JOB_W-1:0]                   in_job,
    input  logic                               in_last,
    output logic [NUM_LANES-1:0]               lane_start,
    output logic [NUM_LANES*JOB_W-1:0]         lane_job,
    input  logic [NUM_LANES-1:0]               lane_done,
    input  logic [NUM_LANES*RES_W-1:0]         lane_result,
    output logic [NUM_LANES-1:0]               lane_ack,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [RES_W-1:0]                   out_result,
    output logic                               out_last,
    output logic [$clog2(NUM_LANES+1)-1:0]     inflight,
    output logic                               done,
    output logic [CNT_W-1:0]                   stat_jobs,
    output logic [CNT_W-1:0]                   stat_stall
);

    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int INF_W = $clog2(NUM_LANES+1);
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_LANES-1);

    typedef enum logic [1:0] {
        L_IDLE,
        L_START,
        L_BUSY,
        L_HELD
    } lane_state_t;

    lane_state_t             state_q [NUM_LANES];
    lane_state_t             state_d [NUM_LANES];
    logic [JOB_W-1:0]        job_q   [NUM_LANES];
    logic [RES_W-1:0]        res_q   [NUM_LANES];
    logic [NUM_LANES-1:0]    last_q;
    logic [NUM_LANES-1:0]    ack_q;
    logic [NUM_LANES-1:0]    capture;
    logic [PTR_W-1:0]        dp_q;
    logic [PTR_W-1:0]        cp_q;
    logic                    input_closed_q;
    logic                    live_q;
    logic                    done_q;
    logic                    accept;
    logic                    out_fire;

    // live_q keeps in_ready low while reset is held, so every output reads 0 in reset.
    always_comb begin
        in_ready   = live_q && !input_closed_q && (state_q[dp_q] == L_IDLE);
        out_valid  = (state_q[cp_q] == L_HELD);
        out_result = res_q[cp_q];
        out_last   = last_q[cp_q];
        accept     = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        done       = done_q;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            capture[i] = (state_q[i] == L_BUSY) && lane_done[i];
        end
    end

    // Lane FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= L_IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Lane FSM next state
    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                L_IDLE:  if (accept && dp_q == PTR_W'(i)) state_d[i] = L_START;
                L_START: state_d[i] = L_BUSY;
                L_BUSY:  if (lane_done[i]) state_d[i] = L_HELD;
                L_HELD:  if (out_fire && cp_q == PTR_W'(i)) state_d[i] = L_IDLE;
                default: state_d[i] = L_IDLE;
            endcase
        end
    end

    // Lane FSM outputs
    always_comb begin
        lane_start = '0;
        lane_job   = '0;
        lane_ack   = ack_q;
        inflight   = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_start[i]              = (state_q[i] == L_START);
            lane_job[i*JOB_W +: JOB_W] = job_q[i];
            if (state_q[i] != L_IDLE) begin
                inflight = inflight + INF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                job_q[i] <= '0;
                res_q[i] <= '0;
            end
            last_q <= '0;
            ack_q  <= '0;
        end else begin
            ack_q <= capture;
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                if (accept && dp_q == PTR_W'(i)) begin
                    job_q[i]  <= in_job;
                    last_q[i] <= in_last;
                end
                if (capture[i]) begin
                    res_q[i] <= lane_result[i*RES_W +: RES_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_q           <= '0;
            cp_q           <= '0;
            input_closed_q <= 1'b0;
            live_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (accept) begin
                dp_q <= (dp_q == LAST_LANE) ? '0 : dp_q + 1'b1;
                if (in_last) input_closed_q <= 1'b1;
            end
            if (out_fire) begin
                cp_q <= (cp_q == LAST_LANE) ? '0 : cp_q + 1'b1;
                if (out_last) done_q <= 1'b1;
            end
        end
    end

`ifdef DAY10_DISPATCH_STATS_EN
    logic [CNT_W-1:0] jobs_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jobs_q  <= '0;
            stall_q <= '0;
        end else begin
            if (accept && jobs_q != '1) jobs_q <= jobs_q + 1'b1;
            if (in_valid && !in_ready && !input_closed_q && stall_q != '1) stall_q <= stall_q + 1'b1;
        end
    end

    assign stat_jobs  = jobs_q;
    assign stat_stall = stall_q;
`else
    assign stat_jobs  = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: doc/day10_lane_dispatcher.md
Name: day10_lane_dispatcher

Overview:
- Successor to the single-solver day10 top-level flow.
- Accepts parsed machine jobs on a valid/ready stream and fans them out round-robin to NUM_LANES parallel configure-machine lanes.
- Captures each lane's result and re-emits results strictly in job-arrival order, forwarding the end-of-input flag with the matching result.
- Sits between the day10 input reader and the day10 output writer; replaces the single store/notify/load handshake chain.

Parameters:
- NUM_LANES, 4, number of solver lanes (>=1).
- JOB_W, 64, width of one packed job (lights, buttons, target).
- RES_W, 16, width of one lane result (min presses).
- CNT_W, 32, width of statistics counters (see Optional Feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted when in_valid && in_ready.
- in_job  in  JOB_W  job payload.
- in_last  in  1  job is the final one.
- lane_start  out  NUM_LANES  1-cycle start pulse per lane.
- lane_job  out  NUM_LANES*JOB_W  per-lane held job, lane i at [i*JOB_W +: JOB_W].
- lane_done  in  NUM_LANES  lane result valid, held until acked.
- lane_result  in  NUM_LANES*RES_W  per-lane result.
- lane_ack  out  NUM_LANES  1-cycle pulse: result captured.
- out_valid  out  1  ordered result available.
- out_ready  in  1  downstream accepts.
- out_result  out  RES_W  result.
- out_last  out  1  result belongs to the last job.
- inflight  out  $clog2(NUM_LANES+1)  lanes not IDLE.
- done  out  1  sticky after the out_last handshake.
- stat_jobs  out  CNT_W  jobs accepted.
- stat_stall  out  CNT_W  cycles with in_valid && !in_ready.

Behaviour:
- Reset values: all lanes IDLE, dispatch pointer dp=0, collect pointer cp=0, input_closed=0.
- All outputs 0 in reset, including lane_job, in_ready, out_valid, done and the statistics counters.
- Per-lane FSM: IDLE -> START -> BUSY -> HELD -> IDLE.
  - IDLE->START: on accept when dp==lane.
  - START->BUSY: unconditional. lane_start is high only while in START.
  - BUSY->HELD: when lane_done=1.
  - HELD->IDLE: on out handshake when cp==lane.
- Dispatch:
  - in_ready = !input_closed && lane[dp]==IDLE (pure function of registers).
  - On accept: latch in_job and in_last into lane dp, then dp <= (dp==NUM_LANES-1) ? 0 : dp+1.
  - An accept with in_last=1 sets input_closed; in_ready stays 0 until reset.
- Lane hold: lane_job is stable from START until the lane returns to IDLE.
- Capture:
  - In BUSY with lane_done=1, register lane_result and go HELD.
  - lane_ack pulses in the following cycle.
  - lane_done in any other state is ignored and produces no ack.
- Collect:
  - out_valid = lane[cp]==HELD; out_result and out_last come from lane cp's registers.
  - On handshake: lane cp -> IDLE, cp advances with wrap.
  - out_* stay stable while out_valid && !out_ready.
- Latency: accept at cycle N -> lane_start at N+1. lane_done sampled at M -> out_valid at M+1. A freed lane can accept again one cycle after its out handshake.
- Ordering: results complete out of order but are emitted in arrival order. A HELD lane at cp!=head waits.
- Simultaneous events:
  - Accept and out handshake in the same cycle on different lanes are both honoured.
  - The same lane can never be both targets, because dispatch needs IDLE and collect needs HELD.
- Counters:
  - inflight = number of non-IDLE lanes, updated each cycle.
  - Range is 0..NUM_LANES.
- done is set on the out handshake with out_last=1 and stays set until reset.
- NUM_LANES=1 degenerates to a serial single-lane flow; pointers are constant 0.
- Reset asserted mid-operation clears all state immediately (asynchronously). Results in flight are discarded; lanes are expected to be reset by the same rst_n.

Optional Feature:
- Macro: DAY10_DISPATCH_STATS_EN.
- Defined:
  - stat_jobs increments on each accept.
  - stat_stall increments each cycle in_valid && !in_ready && !input_closed.
  - Both saturate at all-ones.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- NUM_LANES=4, 4 jobs back-to-back, every lane done after 5 cycles with results 3,1,4,1 -> lane_start pulses at lanes 0..3 on consecutive cycles; out emits 3,1,4,1 in order; out_last only with the last result; done=1.
- Lanes finish in reverse order (lane3 first) with results 10,20,30,40 -> out_valid stays 0 until lane0 is done; output still 10,20,30,40; inflight drops to 0 after the final handshake.
- 6 jobs into 4 lanes with out_ready=0 -> in_ready=0 after 4 accepts; stat_stall counts the waiting cycles (e.g. 7); out_ready=1 releases jobs 5,6 into lanes 0,1.
- out_ready toggled 1010 with a held result of 0x00FF -> out_result is stable while stalled; each result is emitted exactly once.
- Single job with in_last=1 -> after accept in_ready stays 0 even though 3 lanes are IDLE; result emitted with out_last=1; done stays set.
- rst_n pulled low mid-run with 2 lanes BUSY -> all outputs 0 within the same cycle; after release, the first accept goes to lane 0 and done=0.
